// File: rtl/dma_guard_arb.sv
// Two-channel DMA arbiter with protected-region guard: round-robin grants, a single
// outstanding master transfer with timeout, and a lockout released by the CPU PC.
module dma_guard_arb #(
    parameter logic [15:0] SDATA_BASE    = 16'hA000,
    parameter logic [15:0] SDATA_SIZE    = 16'h1000,
    parameter logic [15:0] CTR_BASE      = 16'h9000,
    parameter logic [15:0] CTR_SIZE      = 16'h001F,
    parameter logic [15:0] SCACHE_BASE   = 16'hFFDF,
    parameter logic [15:0] SCACHE_SIZE   = 16'h0033,
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter logic [4:0]  TIMEOUT       = 5'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic        ch0_req,
    input  logic [15:0] ch0_addr,
    input  logic [1:0]  ch0_we,
    input  logic [15:0] ch0_din,
    input  logic        ch1_req,
    input  logic [15:0] ch1_addr,
    input  logic [1:0]  ch1_we,
    input  logic [15:0] ch1_din,
    output logic        ch0_done,
    output logic        ch0_err,
    output logic        ch1_done,
    output logic        ch1_err,
    output logic [15:0] ch_dout,
    output logic        dma_en,
    output logic [15:0] dma_addr,
    output logic [1:0]  dma_we,
    output logic [15:0] dma_din,
    input  logic        dma_ready,
    input  logic        dma_resp,
    input  logic [15:0] dma_dout,
    output logic        locked,
    output logic [7:0]  viol_cnt
);

    typedef enum logic [1:0] {S_LOCK, S_IDLE, S_XFER, S_RESP} state_t;

    state_t      r_state;
    logic        r_last;
    logic        r_ch;
    logic        r_viol_pend;
    logic [4:0]  r_cnt;
    logic        r_dma_en;
    logic        r_done0, r_done1, r_err0, r_err1;
    logic        r_locked;
    logic [7:0]  r_viol;
    logic [15:0] r_dout;
    logic [15:0] r_addr, r_din;
    logic [1:0]  r_we;

    logic        w_any;
    logic        w_sel;
    logic [15:0] w_sel_addr;
    logic        w_sel_prot;
    logic        w_xfer_err;

    // Limit is formed at 17 bits so a region ending past 16'hFFFF does not wrap.
    function automatic logic in_region(input logic [15:0] a, input logic [15:0] base,
                                       input logic [15:0] size);
        logic [16:0] lim;
        lim = {1'b0, base} + {1'b0, size};
        return ({1'b0, a} >= {1'b0, base}) && ({1'b0, a} < lim);
    endfunction

    function automatic logic is_protected(input logic [15:0] a);
        return in_region(a, SDATA_BASE, SDATA_SIZE) ||
               in_region(a, CTR_BASE, CTR_SIZE) ||
               in_region(a, SCACHE_BASE, SCACHE_SIZE);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign w_any      = ch0_req | ch1_req;
    assign w_sel      = (ch0_req & ch1_req) ? ~r_last : ch1_req;
    assign w_sel_addr = w_sel ? ch1_addr : ch0_addr;
    assign w_sel_prot = is_protected(w_sel_addr);
    assign w_xfer_err = dma_ready ? dma_resp : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_LOCK;
            r_locked    <= 1'b1;
            r_dma_en    <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_err0      <= 1'b0;
            r_err1      <= 1'b0;
            r_viol      <= 8'd0;
            r_dout      <= 16'd0;
            r_last      <= 1'b1;
            r_ch        <= 1'b0;
            r_viol_pend <= 1'b0;
            r_cnt       <= 5'd1;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
            case (r_state)
                S_LOCK: begin
                    r_locked <= 1'b1;
                    if (pc == RESET_HANDLER) begin
                        r_state  <= S_IDLE;
                        r_locked <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (w_any) begin
                        r_last <= w_sel;
                        r_ch   <= w_sel;
                        if (w_sel_prot) begin
                            r_viol      <= sat_inc(r_viol);
                            r_viol_pend <= 1'b1;
                            r_state     <= S_RESP;
                            r_done0     <= ~w_sel;
                            r_done1     <= w_sel;
                            r_err0      <= ~w_sel;
                            r_err1      <= w_sel;
                        end else begin
                            r_state  <= S_XFER;
                            r_dma_en <= 1'b1;
                            r_cnt    <= 5'd1;
                        end
                    end
                end
                S_XFER: begin
                    if (dma_ready || r_cnt == TIMEOUT) begin
                        r_dma_en <= 1'b0;
                        r_state  <= S_RESP;
                        r_done0  <= ~r_ch;
                        r_done1  <= r_ch;
                        r_err0   <= ~r_ch & w_xfer_err;
                        r_err1   <= r_ch & w_xfer_err;
                        if (dma_ready && !dma_resp && r_we == 2'b00)
                            r_dout <= dma_dout;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_RESP: begin
                    r_state     <= r_viol_pend ? S_LOCK : S_IDLE;
                    r_locked    <= r_viol_pend;
                    r_viol_pend <= 1'b0;
                end
                default: r_state <= S_LOCK;
            endcase
        end
    end

    // Protected selections never load the master-side latch, so they cannot appear on dma_addr.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_any && !w_sel_prot) begin
            r_addr <= w_sel_addr;
            r_we   <= w_sel ? ch1_we : ch0_we;
            r_din  <= w_sel ? ch1_din : ch0_din;
        end
    end

    assign ch0_done = r_done0;
    assign ch1_done = r_done1;
    assign ch0_err  = r_err0;
    assign ch1_err  = r_err1;
    assign ch_dout  = r_dout;
    assign dma_en   = r_dma_en;
    assign dma_addr = r_addr;
    assign dma_we   = r_we;
    assign dma_din  = r_din;
    assign locked   = r_locked;
    assign viol_cnt = r_viol;

endmodule

// File: tb/tb_dma_guard_arb.sv
// Self-checking bench for dma_guard_arb: directed scenarios plus randomized single-channel
// transactions compared against a transaction-level reference model.
module tb_dma_guard_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic        ch0_req, ch1_req;
    logic [15:0] ch0_addr, ch1_addr, ch0_din, ch1_din;
    logic [1:0]  ch0_we, ch1_we;
    logic        ch0_done, ch0_err, ch1_done, ch1_err;
    logic [15:0] ch_dout;
    logic        dma_en;
    logic [15:0] dma_addr, dma_din;
    logic [1:0]  dma_we;
    logic        dma_ready, dma_resp;
    logic [15:0] dma_dout;
    logic        locked;
    logic [7:0]  viol_cnt;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int          m_viol;
    logic [15:0] m_dout;

    localparam logic [15:0] PC_RUN = 16'h1000;
    localparam int          TMO    = 16;

    dma_guard_arb dut (
        .clk(clk), .reset(reset), .pc(pc),
        .ch0_req(ch0_req), .ch0_addr(ch0_addr), .ch0_we(ch0_we), .ch0_din(ch0_din),
        .ch1_req(ch1_req), .ch1_addr(ch1_addr), .ch1_we(ch1_we), .ch1_din(ch1_din),
        .ch0_done(ch0_done), .ch0_err(ch0_err), .ch1_done(ch1_done), .ch1_err(ch1_err),
        .ch_dout(ch_dout), .dma_en(dma_en), .dma_addr(dma_addr), .dma_we(dma_we),
        .dma_din(dma_din), .dma_ready(dma_ready), .dma_resp(dma_resp), .dma_dout(dma_dout),
        .locked(locked), .viol_cnt(viol_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic bit m_prot(input logic [15:0] a);
        int v;
        v = int'(a);
        return (v >= 'hA000 && v < 'hA000 + 'h1000) ||
               (v >= 'h9000 && v < 'h9000 + 'h001F) ||
               (v >= 'hFFDF && v < 'hFFDF + 'h0033);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; pc = PC_RUN;
        ch0_req = 1'b0; ch1_req = 1'b0;
        ch0_addr = 16'd0; ch1_addr = 16'd0; ch0_we = 2'd0; ch1_we = 2'd0;
        ch0_din = 16'd0; ch1_din = 16'd0;
        dma_ready = 1'b0; dma_resp = 1'b0; dma_dout = 16'd0;
        tick(); tick();
        reset = 1'b0;
        m_viol = 0;
        m_dout = 16'd0;
    endtask

    task automatic unlock();
        pc = RESET_PC();
        tick();
        pc = PC_RUN;
    endtask

    function automatic logic [15:0] RESET_PC();
        return 16'h0000;
    endfunction

    // Runs one request on one channel with a slave answering after rdy_delay extra
    // dma_en cycles, then returns observations after the cycle following done.
    task automatic xfer(input bit ch, input logic [15:0] addr, input logic [1:0] we,
                        input logic [15:0] din, input int rdy_delay, input logic [15:0] sdout,
                        input bit sresp, output int en_cyc, output int lat, output bit got_done,
                        output bit got_err, output bit bus_ok, output bit other_done);
        en_cyc = 0; lat = 0; got_done = 0; got_err = 0; bus_ok = 1; other_done = 0;
        dma_ready = 1'b0; dma_dout = sdout; dma_resp = sresp;
        if (ch) begin
            ch1_addr = addr; ch1_we = we; ch1_din = din; ch1_req = 1'b1;
        end else begin
            ch0_addr = addr; ch0_we = we; ch0_din = din; ch0_req = 1'b1;
        end
        for (int i = 0; i < 40 && !got_done; i++) begin
            tick();
            lat++;
            if (dma_en === 1'b1) begin
                en_cyc++;
                if (dma_addr !== addr || dma_we !== we || dma_din !== din) bus_ok = 0;
                dma_ready = (en_cyc == rdy_delay + 1);
            end else begin
                dma_ready = 1'b0;
            end
            if ((ch ? ch0_done : ch1_done) === 1'b1) other_done = 1;
            if ((ch ? ch1_done : ch0_done) === 1'b1) begin
                got_done = 1;
                got_err  = ch ? ch1_err : ch0_err;
            end
        end
        ch0_req = 1'b0; ch1_req = 1'b0; dma_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (locked !== 1'b1 || dma_en !== 1'b0) $display("FAIL reset_ctrl: locked=%b dma_en=%b, want 1 0", locked, dma_en);
        else n_pass++;
        n_total++;
        if (ch0_done !== 1'b0 || ch1_done !== 1'b0 || ch0_err !== 1'b0 || ch1_err !== 1'b0)
            $display("FAIL reset_done: done=%b%b err=%b%b, want 0", ch0_done, ch1_done, ch0_err, ch1_err);
        else n_pass++;
        n_total++;
        if (viol_cnt !== 8'd0 || ch_dout !== 16'd0) $display("FAIL reset_data: viol=%0d dout=%h, want 0 0", viol_cnt, ch_dout);
        else n_pass++;
    endtask

    task automatic test_lockout();
        bit stuck_ok;
        bit got;
        do_reset();
        ch0_req = 1'b1; ch0_addr = 16'h0200; ch0_we = 2'b00;
        dma_ready = 1'b1; dma_dout = 16'h4321;
        stuck_ok = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (locked !== 1'b1 || dma_en !== 1'b0 || ch0_done !== 1'b0) stuck_ok = 0;
        end
        n_total++;
        if (!stuck_ok) $display("FAIL lock_hold: grant or unlock seen while pc never 0, locked=%b dma_en=%b", locked, dma_en);
        else n_pass++;
        pc = 16'h0000;
        tick();
        pc = PC_RUN;
        n_total++;
        if (locked !== 1'b0) $display("FAIL lock_release: locked=%b, want 0", locked);
        else n_pass++;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (ch0_done === 1'b1) got = 1;
        end
        n_total++;
        if (!got) $display("FAIL lock_pending: ch0_done never arrived after release, want 1");
        else n_pass++;
        ch0_req = 1'b0; dma_ready = 1'b0;
        tick();
    endtask

    task automatic test_basic_read();
        int en, lat; bit d, e, b, o;
        do_reset();
        unlock();
        xfer(1'b0, 16'h0200, 2'b00, 16'h0000, 0, 16'h1234, 1'b0, en, lat, d, e, b, o);
        n_total++;
        if (en != 1) $display("FAIL read_en_cycles: got %0d, want 1", en); else n_pass++;
        n_total++;
        if (!d || e || o) $display("FAIL read_done: done=%b err=%b other=%b, want 1 0 0", d, e, o); else n_pass++;
        n_total++;
        if (lat != 2) $display("FAIL read_latency: done %0d cycles after request cycle, want 2", lat); else n_pass++;
        n_total++;
        if (ch_dout !== 16'h1234) $display("FAIL read_dout: got %h, want 1234", ch_dout); else n_pass++;
        n_total++;
        if (!b) $display("FAIL read_bus: master address/we/din differed from request"); else n_pass++;
    endtask

    task automatic test_round_robin();
        bit exp_ch;
        int ndone, last_t;
        do_reset();
        unlock();
        ch0_addr = 16'h0100; ch0_we = 2'b00; ch1_addr = 16'h0400; ch1_we = 2'b01; ch1_din = 16'hBEEF;
        dma_ready = 1'b1; dma_dout = 16'h55AA; dma_resp = 1'b0;
        ch0_req = 1'b1; ch1_req = 1'b1;
        exp_ch = 1'b0; ndone = 0; last_t = -10;
        for (int i = 0; i < 60 && ndone < 6; i++) begin
            tick();
            if (ch0_done === 1'b1 && ch1_done === 1'b1) begin
                n_total++;
                $display("FAIL rr_both_done: both done pulses in one cycle");
            end else if (ch0_done === 1'b1 || ch1_done === 1'b1) begin
                n_total++;
                if (ch1_done !== exp_ch) $display("FAIL rr_order: grant %0d went to ch%0d, want ch%0d", ndone, ch1_done, exp_ch);
                else n_pass++;
                n_total++;
                if (i - last_t < 3) $display("FAIL rr_gap: done spacing %0d cycles, want >= 3", i - last_t);
                else n_pass++;
                last_t = i;
                exp_ch = ~exp_ch;
                ndone++;
            end
        end
        n_total++;
        if (ndone != 6) $display("FAIL rr_count: got %0d dones, want 6", ndone); else n_pass++;
        ch0_req = 1'b0; ch1_req = 1'b0; dma_ready = 1'b0;
        tick(); tick();
    endtask

    task automatic test_protect();
        logic [15:0] seq [4];
        logic [15:0] bnd [8];
        int en, lat; bit d, e, b, o, p;
        do_reset();
        unlock();
        seq = '{16'hA000, 16'h901E, 16'h0011, 16'hFFFF};
        bnd = '{16'h9FFF, 16'hAFFF, 16'hB000, 16'h8FFF, 16'h9000, 16'h901F, 16'hFFDE, 16'hFFDF};
        for (int k = 0; k < 12; k++) begin
            logic [15:0] a;
            a = (k < 4) ? seq[k] : bnd[k-4];
            p = m_prot(a);
            xfer(1'b1, a, 2'b11, 16'h5A5A, 0, 16'h0000, 1'b0, en, lat, d, e, b, o);
            if (p) m_viol = (m_viol < 255) ? m_viol + 1 : 255;
            n_total++;
            if (!d || e !== p || en != (p ? 0 : 1))
                $display("FAIL prot_%h: done=%b err=%b en_cycles=%0d, want 1 %b %0d", a, d, e, en, p, p ? 0 : 1);
            else n_pass++;
            n_total++;
            if (locked !== p) $display("FAIL prot_lock_%h: locked=%b, want %b", a, locked, p); else n_pass++;
            if (k == 3) begin
                n_total++;
                if (viol_cnt !== 8'd3) $display("FAIL prot_viol3: viol_cnt=%0d, want 3", viol_cnt); else n_pass++;
            end
            if (p) unlock();
        end
        n_total++;
        if (viol_cnt !== 8'(m_viol)) $display("FAIL prot_viol_total: viol_cnt=%0d, want %0d", viol_cnt, m_viol); else n_pass++;
    endtask

    task automatic test_timeout();
        int en, lat; bit d, e, b, o;
        do_reset();
        unlock();
        xfer(1'b0, 16'h0300, 2'b00, 16'h0000, 1000, 16'hDEAD, 1'b0, en, lat, d, e, b, o);
        n_total++;
        if (en != TMO) $display("FAIL tmo_en_cycles: got %0d, want %0d", en, TMO); else n_pass++;
        n_total++;
        if (!d || !e) $display("FAIL tmo_done: done=%b err=%b, want 1 1", d, e); else n_pass++;
        n_total++;
        if (locked !== 1'b0 || ch_dout !== 16'h0000) $display("FAIL tmo_state: locked=%b dout=%h, want 0 0000", locked, ch_dout); else n_pass++;
        xfer(1'b0, 16'h0300, 2'b00, 16'h0000, TMO - 1, 16'h7777, 1'b0, en, lat, d, e, b, o);
        n_total++;
        if (en != TMO || !d || e || ch_dout !== 16'h7777)
            $display("FAIL tmo_last_cycle: en=%0d done=%b err=%b dout=%h, want %0d 1 0 7777", en, d, e, ch_dout, TMO);
        else n_pass++;
    endtask

    task automatic test_random();
        int en, lat; bit d, e, b, o;
        for (int t = 0; t < 40; t++) begin
            bit ch, p, to, sresp;
            logic [15:0] a, din, sdout;
            logic [1:0] we;
            int dly, exp_en;
            ch = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: a = 16'hA000 + 16'($urandom_range(0, 'h0FFF));
                1: a = 16'h9000 + 16'($urandom_range(0, 31));
                2: a = 16'hFFD8 + 16'($urandom_range(0, 39));
                3: a = 16'($urandom());
                default: a = 16'($urandom_range(0, 'h8FFF));
            endcase
            we = 2'($urandom_range(0, 3));
            din = 16'($urandom());
            sdout = 16'($urandom());
            sresp = ($urandom_range(0, 3) == 0);
            dly = $urandom_range(0, 18);
            xfer(ch, a, we, din, dly, sdout, sresp, en, lat, d, e, b, o);
            p = m_prot(a);
            to = (dly >= TMO);
            exp_en = p ? 0 : (to ? TMO : dly + 1);
            if (p) m_viol = (m_viol < 255) ? m_viol + 1 : 255;
            else if (!to && !sresp && we == 2'b00) m_dout = sdout;
            n_total++;
            if (!d || o || e !== (p | to | sresp))
                $display("FAIL rnd%0d_done: ch%0d addr=%h done=%b other=%b err=%b, want 1 0 %b", t, ch, a, d, o, e, p | to | sresp);
            else n_pass++;
            n_total++;
            if (en != exp_en || lat != exp_en + 1)
                $display("FAIL rnd%0d_timing: en=%0d lat=%0d, want %0d %0d", t, en, lat, exp_en, exp_en + 1);
            else n_pass++;
            n_total++;
            if (!b) $display("FAIL rnd%0d_bus: master signals differed from request addr=%h", t, a); else n_pass++;
            n_total++;
            if (ch_dout !== m_dout || viol_cnt !== 8'(m_viol) || locked !== p)
                $display("FAIL rnd%0d_state: dout=%h viol=%0d locked=%b, want %h %0d %b", t, ch_dout, viol_cnt, locked, m_dout, m_viol, p);
            else n_pass++;
            if (p) unlock();
        end
    endtask

    task automatic test_saturation();
        int en, lat; bit d, e, b, o;
        int errs;
        do_reset();
        unlock();
        errs = 0;
        for (int k = 0; k < 256; k++) begin
            xfer(1'b0, 16'hA000 + 16'(k), 2'b00, 16'h0000, 0, 16'h0000, 1'b0, en, lat, d, e, b, o);
            if (!d || !e || en != 0) errs++;
            m_viol = (m_viol < 255) ? m_viol + 1 : 255;
            unlock();
        end
        n_total++;
        if (errs != 0) $display("FAIL sat_attempts: %0d attempts without error done, want 0", errs); else n_pass++;
        n_total++;
        if (viol_cnt !== 8'd255) $display("FAIL sat_viol: viol_cnt=%0d, want 255", viol_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_xfer();
        bit any_done;
        do_reset();
        unlock();
        ch0_req = 1'b1; ch0_addr = 16'h0300; ch0_we = 2'b00; dma_ready = 1'b0;
        tick(); tick(); tick();
        n_total++;
        if (dma_en !== 1'b1) $display("FAIL rst_xfer_pre: dma_en=%b, want 1", dma_en); else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ch0_req = 1'b0;
        n_total++;
        if (dma_en !== 1'b0 || locked !== 1'b1) $display("FAIL rst_xfer_en: dma_en=%b locked=%b, want 0 1", dma_en, locked); else n_pass++;
        any_done = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ch0_done === 1'b1 || ch1_done === 1'b1 || dma_en === 1'b1) any_done = 1;
        end
        n_total++;
        if (any_done) $display("FAIL rst_xfer_nodone: done or dma_en seen after reset abort"); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lockout();
        test_basic_read();
        test_round_robin();
        test_protect();
        test_timeout();
        do_reset();
        unlock();
        test_random();
        test_saturation();
        test_reset_mid_xfer();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
